if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end. Generates sequential fetch PCs and issues them to
//  instruction memory over a valid/ready request channel. Holds in-order responses in a PC-tagged
//  prefetch FIFO and delivers {pc,inst} to decode over a valid/ready channel.
//  Supports redirects (branch/jump/trap): flushes the queue and discards stale in-flight responses.
// PARAMETERS
//  XLEN      64            PC / address width
//  INST_W    32            instruction width
//  DEPTH     4             prefetch FIFO entries (power of 2, >=2); also max in-flight + queued
//  PC_START  64'h80000000  reset fetch PC
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  fetch_en       in   1       1 = fetch allowed; 0 = stop issuing new requests
//  redirect_valid in   1       redirect this cycle (highest priority)
//  redirect_pc    in   XLEN    redirect target; bits [1:0] ignored (treated as 0)
//  req_valid      out  1       fetch request valid
//  req_addr       out  XLEN    fetch address
//  req_ready      in   1       memory accepts request
//  rsp_valid      in   1       in-order response valid (always accepted)
//  rsp_inst       in   INST_W  fetched instruction
//  out_valid      out  1       {out_pc,out_inst} valid to decode
//  out_pc         out  XLEN    PC of delivered instruction
//  out_inst       out  INST_W  delivered instruction
//  out_ready      in   1       decode accepts
// BEHAVIOUR
//  Reset: fetch_pc=PC_START, FIFO empty, outstanding=0, drop_cnt=0, state=IDLE;
//   req_valid=0, req_addr=PC_START, out_valid=0, out_pc=0, out_inst=0.
//  Fires: req_fire=req_valid&req_ready; out_fire=out_valid&out_ready; rsp accepted whenever valid.
//  FSM: IDLE --fetch_en--> RUN; RUN --!fetch_en--> IDLE. Redirect is legal in either state.
//  req_valid = (state==RUN) & (count+outstanding < DEPTH); req_addr = fetch_pc.
//   Both are driven from registers only (no combinational path from redirect).
//   Once asserted, req_valid/req_addr hold until req_fire or a redirect.
//  req_fire: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
//  rsp_valid: outstanding -= 1.
//   If drop_cnt != 0: response discarded, drop_cnt -= 1.
//   Else: {pc_tag,rsp_inst} pushed into FIFO; pc_tag = per-entry PC recorded at request time.
//  FIFO never overflows (credit rule). Pushed entry is visible at out_valid the next cycle (no bypass).
//  out_valid = count!=0; out_pc/out_inst = head entry, held stable until out_fire.
//  Simultaneous push and pop is allowed: count unchanged.
//  Redirect, cycle T:
//   fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; FIFO cleared; out_valid=0 at T+1.
//   drop_cnt <= outstanding + req_fire - rsp_valid_counted, where a response arriving at T is
//    discarded and counted.
//   A request firing at T is stale and its response is dropped.
//   Any out_fire at T is honoured (decode consumed it) before the clear.
//   Requests for the new PC may issue from T+1 if credit allows; stale responses still drain
//    via drop_cnt.
//  Back-to-back redirects: each recomputes drop_cnt from current outstanding; last target wins.
//  rst mid-operation: all state returns to reset values the next edge.
//   Memory must also be reset so no stale responses arrive.
//  Widths: count, outstanding, drop_cnt are $clog2(DEPTH+1) bits. outstanding never exceeds DEPTH.
// TESTING
//  1 Reset release, fetch_en=1, req_ready=1, 1-cycle rsp -> req_addr 0x80000000,04,08...;
//    out_pc matches, out_inst = rsp_inst in order.
//  2 out_ready=0, DEPTH=4 -> exactly 4 requests issue, req_valid drops.
//    out_ready=1 for 1 cycle -> exactly 1 new request.
//  3 req_ready=0 for 3 cycles at addr 0x80000008 -> req_valid/req_addr held stable; issues on ready.
//  4 Redirect to 0x80001003 with 2 outstanding -> next req_addr 0x80001000;
//    2 stale responses dropped; first out_pc 0x80001000.
//  5 Redirect coincident with req_fire, rsp_valid and out_fire -> consumed entry counted once;
//    stale rsp and stale request's rsp both dropped; no FIFO entry survives.
//  6 fetch_en low mid-stream -> no new requests; in-flight responses still queued and delivered.
//    rst asserted mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetch PCs to memory, queues in-order
// responses tagged with their PC, and hands {pc,inst} to decode. Redirects flush the queue
// and drain stale in-flight responses through a drop counter.
module if_prefetch_queue #(
  parameter int unsigned      XLEN     = 64,
  parameter int unsigned      INST_W   = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  PC_START = 'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              req_valid,
  output logic [XLEN-1:0]   req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_inst,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be kept; fetch is sequential, so it tracks fetch_pc
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic              req_valid_q, req_valid_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0]   pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic req_fire, out_fire, push, pop, credit_ok;

  assign req_fire  = req_valid_q & req_ready;
  assign out_valid = (count_q != '0);
  assign out_fire  = out_valid & out_ready;
  assign push      = rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;
  assign pop       = out_fire & ~redirect_valid;

  assign req_valid = req_valid_q;
  assign req_addr  = fetch_pc_q;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : '0;

  // Next-state for FSM, PCs, credit counters and FIFO pointers
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_valid);

    unique case (state_q)
      StIdle:  if (fetch_en)  state_d = StRun;
      StRun:   if (!fetch_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      // everything still in flight after this edge belongs to the old stream
      drop_cnt_d = outstanding_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(4);
      if (rsp_valid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end

    credit_ok   = ({1'b0, count_d} + {1'b0, outstanding_d}) < DepthW;
    // a pending request stays up until accepted unless a redirect retargets it
    req_valid_d = (req_valid_q & ~req_fire & ~redirect_valid) |
                  ((state_d == StRun) & credit_ok);
  end

  // Control and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      fetch_pc_q    <= PC_START;
      rsp_pc_q      <= PC_START;
      req_valid_q   <= 1'b0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      req_valid_q   <= req_valid_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      inst_mem_q[wr_ptr_q] <= rsp_inst;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a 1-cycle in-order memory model.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  int          total = 0;
  int          bad   = 0;
  int          nreq  = 0;
  logic        mem_on;
  logic [63:0] memq [$];

  always #5 clk = ~clk;

  if_prefetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_inst      (rsp_inst),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_ready     (out_ready)
  );

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return ~a[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge: drive memory for the coming edge, then advance one cycle.
  task automatic cyc();
    if (rst) memq.delete();
    if (mem_on && !rst && memq.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_inst  = inst_of(memq.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_inst  = '0;
    end
    if (req_valid && req_ready && !rst) begin
      memq.push_back(req_addr);
      nreq++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    req_ready = 1'b0; out_ready = 1'b0; mem_on = 1'b1;
    cyc();
    cyc();
    rst  = 1'b0;
    nreq = 0;
  endtask

  // Wait (bounded) for the next delivered entry, check it, then let the cycle proceed.
  task automatic expect_out(input string tag, input logic [63:0] pc);
    for (int i = 0; i < 12; i++) begin
      if (out_valid) break;
      cyc();
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_inst"}, 64'(out_inst), 64'(inst_of(pc)));
    cyc();
  endtask

  initial begin
    rsp_valid = 1'b0; rsp_inst = '0;
    @(negedge clk);
    do_reset();
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_addr", req_addr, 64'h8000_0000);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);

    // Sequential streaming, then a 3-cycle req_ready stall at 0x80000008
    fetch_en = 1'b1; req_ready = 1'b1; out_ready = 1'b1;
    cyc();
    chk("t1_req_valid", 64'(req_valid), 64'd1);
    chk("t1_addr0", req_addr, 64'h8000_0000);
    cyc();
    chk("t1_addr1", req_addr, 64'h8000_0004);
    cyc();
    chk("t1_addr2", req_addr, 64'h8000_0008);
    chk("t1_out_pc0", out_pc, 64'h8000_0000);
    chk("t1_out_inst0", 64'(out_inst), 64'(inst_of(64'h8000_0000)));
    req_ready = 1'b0;
    cyc();
    chk("t1_out_pc1", out_pc, 64'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", 64'(req_valid), 64'd1);
      chk("t3_hold_addr", req_addr, 64'h8000_0008);
      if (i < 2) cyc();
    end
    req_ready = 1'b1;
    cyc();
    chk("t3_next_addr", req_addr, 64'h8000_000C);
    expect_out("t3_o08", 64'h8000_0008);
    expect_out("t3_o0c", 64'h8000_000C);

    // Credit limit: decode stalled, only DEPTH requests may be in the system
    do_reset();
    fetch_en = 1'b1; req_ready = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("t2_nreq4", 64'(nreq), 64'd4);
    chk("t2_req_valid_low", 64'(req_valid), 64'd0);
    chk("t2_head", out_pc, 64'h8000_0000);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t2_credit_valid", 64'(req_valid), 64'd1);
    chk("t2_credit_addr", req_addr, 64'h8000_0010);
    for (int i = 0; i < 5; i++) cyc();
    chk("t2_nreq5", 64'(nreq), 64'd5);
    chk("t2_req_valid_low2", 64'(req_valid), 64'd0);
    chk("t2_head2", out_pc, 64'h8000_0004);

    // Redirect with two responses still held in memory
    do_reset();
    fetch_en = 1'b1; req_ready = 1'b1; out_ready = 1'b1; mem_on = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t4_two_out", 64'(nreq), 64'd2);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1003; req_ready = 1'b0;
    cyc();
    redirect_valid = 1'b0; req_ready = 1'b1; mem_on = 1'b1;
    chk("t4_redir_valid", 64'(req_valid), 64'd1);
    chk("t4_redir_addr", req_addr, 64'h8000_1000);
    chk("t4_flushed", 64'(out_valid), 64'd0);
    expect_out("t4_o1000", 64'h8000_1000);
    expect_out("t4_o1004", 64'h8000_1004);

    // Redirect coincident with req_fire, rsp_valid and out_fire
    do_reset();
    fetch_en = 1'b1; req_ready = 1'b1; out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("t5_head", out_pc, 64'h8000_0000);
    chk("t5_fire_pending", 64'(req_valid & req_ready), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    cyc();
    redirect_valid = 1'b0;
    chk("t5_flushed0", 64'(out_valid), 64'd0);
    chk("t5_addr", req_addr, 64'h8000_2000);
    cyc();
    chk("t5_flushed1", 64'(out_valid), 64'd0);
    expect_out("t5_o2000", 64'h8000_2000);
    expect_out("t5_o2004", 64'h8000_2004);

    // fetch_en dropped mid-stream: the pending request completes, nothing new issues
    do_reset();
    fetch_en = 1'b1; req_ready = 1'b1; out_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    fetch_en = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("t6_nreq3", 64'(nreq), 64'd3);
    chk("t6_req_idle", 64'(req_valid), 64'd0);
    out_ready = 1'b1;
    expect_out("t6_o00", 64'h8000_0000);
    expect_out("t6_o04", 64'h8000_0004);
    expect_out("t6_o08", 64'h8000_0008);
    chk("t6_empty", 64'(out_valid), 64'd0);

    // Reset in the middle of traffic
    fetch_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("t6_busy", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cyc();
    chk("t6_rst_req_valid", 64'(req_valid), 64'd0);
    chk("t6_rst_req_addr", req_addr, 64'h8000_0000);
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_out_pc", out_pc, 64'd0);
    chk("t6_rst_out_inst", 64'(out_inst), 64'd0);
    rst = 1'b0;
    cyc();
    chk("t6_restart_addr", req_addr, 64'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
